// File: rtl/bcrypt_word_pack.sv
// Byte-to-word packer for the bcrypt key/salt register stages.
// Bytes are assembled into 32-bit words and queued in a 2-entry buffer.
// The buffer head is presented on dout/dout_valid, and rd_en pops it.
module bcrypt_word_pack #(
    parameter int BIG_ENDIAN = 1,
    parameter int N          = 32
) (
    input  logic         CLK,
    input  logic         rst,
    input  logic [7:0]   din,
    input  logic         wr_en,
    input  logic         last,
    output logic         full,
    output logic [N-1:0] dout,
    output logic         dout_last,
    output logic         dout_valid,
    input  logic         rd_en,
    output logic [1:0]   word_count
);

    logic [1:0]   byte_cnt;
    logic [N-1:0] asm_q;
    logic [N-1:0] tail_word;
    logic         tail_last;

    logic         closing;
    logic         pop;
    logic         accept;
    logic         push;
    logic [N-1:0] packed_word;
    logic [1:0]   byte_cnt_next;
    logic [1:0]   word_count_next;
    int unsigned  slot_lo;
    int unsigned  cnt_i;

    // Accept/close/pop decisions for this edge.
    // A last-terminated word can close from slots 0..2 while full is low and
    // two words are already buffered; that byte is held off unless the head
    // is popped at the same edge, so the buffer can never overflow.
    always_comb begin
        closing = last || (byte_cnt == 2'd3);
        pop     = rd_en && (word_count != 2'd0);
        accept  = wr_en && !full && !(closing && (word_count == 2'd2) && !pop);
        push    = accept && closing;
    end

    // Current word with the incoming byte in slot byte_cnt and higher slots zeroed.
    always_comb begin
        packed_word = '0;
        slot_lo     = 0;
        cnt_i       = 32'(byte_cnt);
        for (int unsigned k = 0; k < 4; k++) begin
            slot_lo = (BIG_ENDIAN != 0) ? (24 - 8 * k) : (8 * k);
            if (k < cnt_i) begin
                packed_word[slot_lo +: 8] = asm_q[slot_lo +: 8];
            end else if (k == cnt_i) begin
                packed_word[slot_lo +: 8] = din;
            end
        end
    end

    // Next byte slot and buffer occupancy.
    always_comb begin
        byte_cnt_next = byte_cnt;
        if (accept) begin
            byte_cnt_next = closing ? 2'd0 : byte_cnt + 2'd1;
        end
        word_count_next = word_count + {1'b0, push} - {1'b0, pop};
    end

    // Assembly register, 2-entry buffer with registered head, and full flag.
    always_ff @(posedge CLK) begin
        if (rst) begin
            byte_cnt   <= '0;
            asm_q      <= '0;
            dout       <= '0;
            dout_last  <= 1'b0;
            dout_valid <= 1'b0;
            tail_word  <= '0;
            tail_last  <= 1'b0;
            word_count <= '0;
            full       <= 1'b0;
        end else begin
            byte_cnt   <= byte_cnt_next;
            word_count <= word_count_next;
            dout_valid <= (word_count_next != 2'd0);
            full       <= (byte_cnt_next == 2'd3) && (word_count_next == 2'd2);

            if (accept) begin
                asm_q <= closing ? '0 : packed_word;
            end

            case ({push, pop})
                2'b10: begin
                    if (word_count == 2'd0) begin
                        dout      <= packed_word;
                        dout_last <= last;
                    end else begin
                        tail_word <= packed_word;
                        tail_last <= last;
                    end
                end
                2'b01: begin
                    dout      <= tail_word;
                    dout_last <= tail_last;
                    tail_word <= '0;
                    tail_last <= 1'b0;
                end
                2'b11: begin
                    if (word_count == 2'd1) begin
                        dout      <= packed_word;
                        dout_last <= last;
                    end else begin
                        dout      <= tail_word;
                        dout_last <= tail_last;
                        tail_word <= packed_word;
                        tail_last <= last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcrypt_word_pack.sv
// Scoreboard bench: a big-endian and a little-endian packer share one input
// stream; a byte-list reference model predicts words, a monitor checks them.
module tb_bcrypt_word_pack;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  din = '0;
    logic        wr_en = 1'b0;
    logic        last = 1'b0;
    logic        rd_en = 1'b0;

    logic        full_be, full_le;
    logic [31:0] d_be, d_le;
    logic        dl_be, dl_le;
    logic        dv_be, dv_le;
    logic [1:0]  wc_be, wc_le;

    always #5 CLK = ~CLK;

    bcrypt_word_pack #(.BIG_ENDIAN(1), .N(32)) dut_be (
        .CLK(CLK), .rst(rst), .din(din), .wr_en(wr_en), .last(last),
        .full(full_be), .dout(d_be), .dout_last(dl_be), .dout_valid(dv_be),
        .rd_en(rd_en), .word_count(wc_be)
    );

    bcrypt_word_pack #(.BIG_ENDIAN(0), .N(32)) dut_le (
        .CLK(CLK), .rst(rst), .din(din), .wr_en(wr_en), .last(last),
        .full(full_le), .dout(d_le), .dout_last(dl_le), .dout_valid(dv_le),
        .rd_en(rd_en), .word_count(wc_le)
    );

    typedef struct {
        logic [31:0] be;
        logic [31:0] le;
        logic        lst;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  cur[$];
    int          checks = 0;
    int          failures = 0;
    bit          mon_on = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // One clock of stimulus; the reference model is updated after the edge.
    task automatic cycle(input logic r, input logic [7:0] d, input logic w,
                         input logic l, input logic rd);
        bit   m_full, acc, cls, pp;
        int   occ;
        exp_t e;
        @(negedge CLK);
        rst = r; din = d; wr_en = w; last = l; rd_en = rd;
        occ    = exp_q.size();
        m_full = (cur.size() == 3) && (occ == 2);
        if (mon_on) begin
            chk("full_be", {31'b0, full_be}, {31'b0, m_full});
            chk("full_le", {31'b0, full_le}, {31'b0, m_full});
        end
        cls = l || (cur.size() == 3);
        pp  = rd && (occ > 0);
        acc = w && !m_full && !(cls && (occ == 2) && !pp);
        @(posedge CLK);
        #1;
        if (r) begin
            cur.delete();
            exp_q.delete();
        end else if (acc) begin
            cur.push_back(d);
            if (cls) begin
                e.be = '0;
                e.le = '0;
                for (int k = 0; k < cur.size(); k++) begin
                    e.be = e.be | (32'(cur[k]) << (24 - 8 * k));
                    e.le = e.le | (32'(cur[k]) << (8 * k));
                end
                e.lst = l;
                exp_q.push_back(e);
                cur.delete();
            end
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: compares the presented head against the scoreboard; a head is
    // retired when rd_en is asserted while it is valid.
    always begin
        @(negedge CLK);
        #2;
        if (mon_on) begin
            chk("word_count_be", {30'b0, wc_be}, exp_q.size());
            chk("word_count_le", {30'b0, wc_le}, exp_q.size());
            chk("valid_be", {31'b0, dv_be}, {31'b0, exp_q.size() != 0});
            chk("valid_le", {31'b0, dv_le}, {31'b0, exp_q.size() != 0});
            if (exp_q.size() == 0) begin
                chk("empty_dout_be", d_be, 32'h0);
                chk("empty_dout_le", d_le, 32'h0);
                chk("empty_last_be", {31'b0, dl_be}, 32'h0);
            end else begin
                chk("dout_be", d_be, exp_q[0].be);
                chk("dout_le", d_le, exp_q[0].le);
                chk("last_be", {31'b0, dl_be}, {31'b0, exp_q[0].lst});
                chk("last_le", {31'b0, dl_le}, {31'b0, exp_q[0].lst});
                if (rd_en && !rst) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        bit r, w, l, rd;
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        mon_on = 1;

        // Plain 4-byte pack.
        cycle(1'b0, 8'h11, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h22, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h33, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h44, 1'b1, 1'b0, 1'b0);
        chk("plan_pack_be", d_be, 32'h11223344);
        chk("plan_pack_le", d_le, 32'h44332211);
        drain(2);

        // Last padding from slot 1 and from slot 0.
        cycle(1'b0, 8'hAA, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'hBB, 1'b1, 1'b1, 1'b0);
        chk("plan_pad_le", d_le, 32'h0000BBAA);
        chk("plan_pad_be", d_be, 32'hAABB0000);
        cycle(1'b0, 8'h01, 1'b1, 1'b1, 1'b0);
        chk("plan_pad_count", {30'b0, wc_le}, 32'd2);
        drain(3);

        // Back-pressure.
        for (int i = 0; i < 11; i++) cycle(1'b0, 8'(i), 1'b1, 1'b0, 1'b0);
        chk("plan_bp_full", {31'b0, full_be}, 32'd1);
        cycle(1'b0, 8'h0B, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h0B, 1'b1, 1'b0, 1'b1);
        chk("plan_bp_head", d_be, 32'h04050607);
        chk("plan_bp_release", {31'b0, full_be}, 32'd0);
        cycle(1'b0, 8'h0B, 1'b1, 1'b0, 1'b0);
        drain(4);

        // Simultaneous push and pop.
        for (int i = 1; i <= 7; i++) cycle(1'b0, 8'(i), 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'h08, 1'b1, 1'b0, 1'b1);
        chk("plan_pp_count", {30'b0, wc_be}, 32'd1);
        chk("plan_pp_head", d_be, 32'h05060708);
        drain(2);

        // Reset with one word buffered and two bytes assembled.
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'(8'h11 * (i + 1)), 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("plan_rst_valid", {31'b0, dv_be}, 32'd0);
        chk("plan_rst_dout", d_be, 32'h0);
        cycle(1'b0, 8'hDE, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'hAD, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'hBE, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 8'hEF, 1'b1, 1'b0, 1'b0);
        chk("plan_rst_word", d_be, 32'hDEADBEEF);
        drain(2);

        // Pops while empty.
        drain(3);
        chk("plan_empty_count", {30'b0, wc_be}, 32'd0);

        // Randomised traffic, biased toward a filling buffer.
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            w  = ($urandom_range(0, 3) != 0);
            l  = ($urandom_range(0, 6) == 0);
            rd = !r && ($urandom_range(0, 2) == 0);
            cycle(r, 8'($urandom), w, l, rd);
        end
        drain(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcrypt_word_pack.md
Name: bcrypt_word_pack

Overview:
- Byte-to-word packer feeding the 32-bit enable/reset register stages of the bcrypt pipeline.
- Accepts a byte stream (key/salt material) and assembles 32-bit words. Completed words queue in a 2-entry word buffer.
- Presents the buffer head as dout/dout_valid; dout_valid drives the downstream register's en, and rd_en pops the head.
- Supports early word termination with zero padding on a "last" byte.

Parameters:
- BIG_ENDIAN, 1, 1: first byte of a word lands in bits [31:24]; 0: first byte lands in bits [7:0].
- N, 32, output word width; fixed at 32 (4 bytes). Other values are unsupported.

Ports:
- CLK  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- din  input  8  input byte.
- wr_en  input  1  byte write strobe; accepted only when wr_en && !full.
- last  input  1  qualifies an accepted byte as the final byte of the stream; the current word is closed and zero-padded.
- full  output  1  registered back-pressure for the input side.
- dout  output  32  head word of the buffer; 0 when the buffer is empty.
- dout_last  output  1  head word was closed by last; 0 when empty.
- dout_valid  output  1  buffer non-empty.
- rd_en  input  1  pops the head when dout_valid=1; ignored when dout_valid=0.
- word_count  output  2  words currently buffered (0..2).

Behaviour:
- Reset (rst=1 at a clock edge): byte_cnt=0, assembly register=0, buffer empty, dout=0, dout_last=0, dout_valid=0, full=0, word_count=0. Reset wins over any simultaneous wr_en/rd_en. A partially assembled word is discarded.
- Byte counter byte_cnt (0..3) tracks the next byte slot in the assembly register.
- Accepted byte with last=0 and byte_cnt<3: write the byte into slot byte_cnt; byte_cnt++.
- Word close: an accepted byte with byte_cnt==3, or with last=1 at any byte_cnt.
  - Slot byte_cnt receives the byte; slots above byte_cnt are forced to 0.
  - The completed word plus its last flag are pushed into the buffer; byte_cnt returns to 0 and the assembly register clears.
- Slot mapping:
  - BIG_ENDIAN=1: slot k occupies bits [31-8k : 24-8k].
  - BIG_ENDIAN=0: slot k occupies bits [8k+7 : 8k].
- Latency: the word-closing byte is accepted at edge t; dout_valid=1 with that word after edge t (visible in cycle t+1) when the buffer was empty.
- Buffer: 2-entry FIFO, in order.
  - Pop occurs at an edge where rd_en=1 and dout_valid=1.
  - Push and pop at the same edge: word_count is unchanged; the head advances to the next word in order.
  - Pop from word_count=1 with no push: dout and dout_last become 0 and dout_valid becomes 0 the next cycle.
- full is registered: full=1 iff byte_cnt==3 and word_count==2 after the current edge.
  - A byte with full=1 is not accepted, even if last=1 and even if rd_en pops in the same cycle; the input must retry next cycle.
  - Bytes into slots 0..2 are accepted while the buffer is full, because they do not push.
- wr_en while full=1: no state change on the input side.
- rd_en while empty: no state change.

Test Plan:
- Big-endian pack: BIG_ENDIAN=1; bytes 0x11,0x22,0x33,0x44 on 4 consecutive cycles, rd_en=0 -> dout=0x11223344, dout_last=0, dout_valid=1, word_count=1, one cycle after the 4th byte.
- Little-endian pack plus last padding: BIG_ENDIAN=0; bytes 0xAA,0xBB with last=1 on 0xBB -> dout=0x0000BBAA, dout_last=1. A following 0x01 (last=1) with byte_cnt=0 -> second word 0x00000001, dout_last=1.
- Back-pressure: BIG_ENDIAN=1; 11 bytes 0x00..0x0A streamed with rd_en=0.
  - Words 0x00010203 and 0x04050607 are buffered; bytes 0x08,0x09,0x0A are accepted and full=1.
  - Byte 0x0B is held off while full=1.
  - Pulse rd_en once -> dout=0x04050607 and full=0 the next cycle; 0x0B is then accepted, giving word 0x08090A0B.
- Simultaneous push/pop: word_count=1 holding 0x01020304; the closing byte of 0x05060708 and rd_en=1 in the same cycle -> word_count stays 1, dout=0x05060708.
- Reset mid-operation: 2 bytes assembled and 1 word buffered; rst=1 for one cycle -> dout=0, dout_valid=0, full=0, word_count=0. Next bytes 0xDE,0xAD,0xBE,0xEF -> dout=0xDEADBEEF with no residue from before the reset.
- Empty pop: rd_en=1 with the buffer empty for 3 cycles -> all outputs remain at their reset values.
